// File: rtl/phy_pkg.sv
// Shared characters and state encodings for the serial PHY link logic.
package phy_pkg;

    localparam logic [7:0] COMMA_CHAR = 8'hBC;
    localparam logic [7:0] IDLE_CHAR  = 8'h7C;

    typedef enum logic [1:0] {
        L_SEARCH = 2'd0,
        L_CHECK  = 2'd1,
        L_ACTIVE = 2'd2
    } lane_state_e;

    typedef enum logic [1:0] {
        DOWN  = 2'd0,
        TRAIN = 2'd1,
        UP    = 2'd2,
        HOLD  = 2'd3
    } link_state_e;

endpackage

// File: rtl/phy_lane_sync.sv
// Per-lane comma synchronizer: acquires on a run of commas, drops on a run of decode errors.
module phy_lane_sync
    import phy_pkg::*;
#(
    parameter logic [7:0]  COMMA      = COMMA_CHAR,
    parameter int unsigned SYNC_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 3
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       stb,
    input  logic       err,
    output logic       active
);

    localparam logic [3:0] SYNC_LIM = 4'(SYNC_COUNT);
    localparam logic [3:0] LOSS_LIM = 4'(LOSS_COUNT);

    lane_state_e state_q, state_d;
    logic [3:0]  sync_cnt_q, sync_cnt_d;
    logic [3:0]  err_cnt_q, err_cnt_d;
    logic [3:0]  sync_inc, err_inc;

    assign sync_inc = sync_cnt_q + 4'd1;
    assign err_inc  = err_cnt_q + 4'd1;

    // Next-state logic; nothing moves on cycles without a strobe.
    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (stb) begin
            unique case (state_q)
                L_SEARCH: begin
                    if (rx_byte == COMMA) begin
                        state_d    = L_CHECK;
                        sync_cnt_d = 4'd1;
                    end
                end
                L_CHECK: begin
                    if (rx_byte != COMMA) begin
                        state_d    = L_SEARCH;
                        sync_cnt_d = 4'd0;
                    end else if (sync_inc == SYNC_LIM) begin
                        state_d    = L_ACTIVE;
                        sync_cnt_d = 4'd0;
                    end else begin
                        sync_cnt_d = sync_inc;
                    end
                end
                L_ACTIVE: begin
                    // Byte value is irrelevant here; only decode errors matter.
                    if (!err) begin
                        err_cnt_d = 4'd0;
                    end else if (err_inc == LOSS_LIM) begin
                        state_d   = L_SEARCH;
                        err_cnt_d = 4'd0;
                    end else begin
                        err_cnt_d = err_inc;
                    end
                end
                default: begin
                    state_d    = L_SEARCH;
                    sync_cnt_d = 4'd0;
                    err_cnt_d  = 4'd0;
                end
            endcase
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q    <= L_SEARCH;
            sync_cnt_q <= 4'd0;
            err_cnt_q  <= 4'd0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign active = (state_q == L_ACTIVE);

endmodule

// File: rtl/phy_link_ctrl.sv
// Two-lane link bring-up: per-lane sync plus link sequencing and retrain counting.
module phy_link_ctrl
    import phy_pkg::*;
#(
    parameter logic [7:0]  COMMA        = COMMA_CHAR,
    parameter int unsigned SYNC_COUNT   = 4,
    parameter int unsigned LOSS_COUNT   = 3,
    parameter int unsigned RETRAIN_HOLD = 16
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] rx0_byte,
    input  logic       rx0_stb,
    input  logic       rx0_err,
    input  logic [7:0] rx1_byte,
    input  logic       rx1_stb,
    input  logic       rx1_err,
    output logic [1:0] lane_active,
    output logic       link_up,
    output logic       tx_train,
    output logic [7:0] retrain_cnt
);

    localparam logic [7:0] HOLD_LAST = 8'(RETRAIN_HOLD - 1);

    link_state_e state_q, state_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [7:0]  retrain_cnt_q, retrain_cnt_d;
    logic        act0, act1;

    phy_lane_sync #(
        .COMMA      (COMMA),
        .SYNC_COUNT (SYNC_COUNT),
        .LOSS_COUNT (LOSS_COUNT)
    ) u_lane0 (
        .clk_4f  (clk_4f),
        .reset   (reset),
        .rx_byte (rx0_byte),
        .stb     (rx0_stb),
        .err     (rx0_err),
        .active  (act0)
    );

    phy_lane_sync #(
        .COMMA      (COMMA),
        .SYNC_COUNT (SYNC_COUNT),
        .LOSS_COUNT (LOSS_COUNT)
    ) u_lane1 (
        .clk_4f  (clk_4f),
        .reset   (reset),
        .rx_byte (rx1_byte),
        .stb     (rx1_stb),
        .err     (rx1_err),
        .active  (act1)
    );

    assign lane_active = {act1, act0};

    // Link sequencing; HOLD always runs its full length even if lanes recover early.
    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        retrain_cnt_d = retrain_cnt_q;
        unique case (state_q)
            DOWN: state_d = TRAIN;
            TRAIN: begin
                if (lane_active == 2'b11) state_d = UP;
            end
            UP: begin
                if (lane_active != 2'b11) begin
                    state_d    = HOLD;
                    hold_cnt_d = 8'd0;
                    if (retrain_cnt_q != 8'hFF) retrain_cnt_d = retrain_cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = TRAIN;
                    hold_cnt_d = 8'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: state_d = DOWN;
        endcase
    end

    // Link state and counters with synchronous reset.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q       <= DOWN;
            hold_cnt_q    <= 8'd0;
            retrain_cnt_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            retrain_cnt_q <= retrain_cnt_d;
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        link_up  = (state_q == UP);
        tx_train = (state_q == TRAIN) || (state_q == HOLD);
    end

    assign retrain_cnt = retrain_cnt_q;

endmodule

// File: tb/tb_phy_link_ctrl.sv
// Directed bench for phy_link_ctrl with hand-computed expectations.
module tb_phy_link_ctrl;

    logic       clk_4f = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] rx0_byte = 8'h00;
    logic       rx0_stb  = 1'b0;
    logic       rx0_err  = 1'b0;
    logic [7:0] rx1_byte = 8'h00;
    logic       rx1_stb  = 1'b0;
    logic       rx1_err  = 1'b0;
    logic [1:0] lane_active;
    logic       link_up;
    logic       tx_train;
    logic [7:0] retrain_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] BC = 8'hBC;

    phy_link_ctrl dut (
        .clk_4f      (clk_4f),
        .reset       (reset),
        .rx0_byte    (rx0_byte),
        .rx0_stb     (rx0_stb),
        .rx0_err     (rx0_err),
        .rx1_byte    (rx1_byte),
        .rx1_stb     (rx1_stb),
        .rx1_err     (rx1_err),
        .lane_active (lane_active),
        .link_up     (link_up),
        .tx_train    (tx_train),
        .retrain_cnt (retrain_cnt)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of lane inputs, then return 1 time unit after the edge.
    task automatic cyc(input logic [7:0] b0, input logic s0, input logic e0,
                       input logic [7:0] b1, input logic s1, input logic e1);
        rx0_byte = b0; rx0_stb = s0; rx0_err = e0;
        rx1_byte = b1; rx1_stb = s1; rx1_err = e1;
        @(posedge clk_4f);
        #1;
        rx0_stb = 1'b0; rx0_err = 1'b0;
        rx1_stb = 1'b0; rx1_err = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wait_up(input string tag, input int budget);
        for (int i = 0; i < budget && !link_up; i++) idle(1);
        check(tag, {31'd0, link_up}, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_active", {30'd0, lane_active}, 32'd0);
        check("rst_retrain", {24'd0, retrain_cnt}, 32'd0);
        check("rst_train", {31'd0, tx_train}, 32'd0);
        idle(1);
        check("train_after_down", {31'd0, tx_train}, 32'd1);
        check("no_link_in_train", {31'd0, link_up}, 32'd0);

        // Four commas on both lanes
        for (int i = 0; i < 3; i++) cyc(BC, 1'b1, 1'b0, BC, 1'b1, 1'b0);
        check("active_after3", {30'd0, lane_active}, 32'd0);
        cyc(BC, 1'b1, 1'b0, BC, 1'b1, 1'b0);
        check("active_after4", {30'd0, lane_active}, 32'd3);
        check("link_lags_active", {31'd0, link_up}, 32'd0);
        idle(1);
        check("link_up", {31'd0, link_up}, 32'd1);
        check("train_off_when_up", {31'd0, tx_train}, 32'd0);

        // Broken comma run on lane 0
        do_reset();
        idle(1);
        cyc(BC, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(BC, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(BC, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(BC, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("break_not_active", {30'd0, lane_active}, 32'd0);
        cyc(BC, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("break_active", {30'd0, lane_active}, 32'd1);
        for (int i = 0; i < 4; i++) cyc(8'h00, 1'b0, 1'b0, BC, 1'b1, 1'b0);
        idle(1);
        check("link_up2", {31'd0, link_up}, 32'd1);

        // Sparse errors do not drop lane 1
        cyc(8'h00, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1);
        cyc(8'h00, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1);
        cyc(8'h00, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 8'h44, 1'b1, 1'b1);
        cyc(8'h00, 1'b0, 1'b0, 8'h55, 1'b1, 1'b1);
        idle(1);
        check("sparse_err_active", {30'd0, lane_active}, 32'd3);
        check("sparse_err_link", {31'd0, link_up}, 32'd1);

        // Strobe-less cycles with err high must not count
        cyc(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b0, 8'h66, 1'b1, 1'b0);

        // Three consecutive errors drop lane 1
        cyc(8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cyc(8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        check("two_err_active", {30'd0, lane_active}, 32'd3);
        cyc(8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        check("loss_active", {30'd0, lane_active}, 32'd1);
        idle(1); // HOLD entered on this edge
        check("loss_link", {31'd0, link_up}, 32'd0);
        check("loss_train", {31'd0, tx_train}, 32'd1);
        check("retrain1", {24'd0, retrain_cnt}, 32'd1);

        // Resync lane 1 during HOLD; HOLD still runs its full length
        for (int i = 0; i < 4; i++) cyc(8'h00, 1'b0, 1'b0, BC, 1'b1, 1'b0);
        check("resync_in_hold", {30'd0, lane_active}, 32'd3);
        idle(11);
        check("hold_h15", {31'd0, link_up}, 32'd0);
        idle(1);
        check("hold_h16_link", {31'd0, link_up}, 32'd0);
        check("hold_h16_train", {31'd0, tx_train}, 32'd1);
        idle(1);
        check("up_h17", {31'd0, link_up}, 32'd1);

        // Both lanes lost on the same strobe
        for (int i = 0; i < 3; i++) cyc(8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1);
        check("both_loss", {30'd0, lane_active}, 32'd0);
        idle(1);
        check("retrain2", {24'd0, retrain_cnt}, 32'd2);
        idle(5);

        // Reset mid-HOLD
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("midrst_retrain", {24'd0, retrain_cnt}, 32'd0);
        check("midrst_train", {31'd0, tx_train}, 32'd0);
        check("midrst_link", {31'd0, link_up}, 32'd0);

        // Comma on the loss strobe does not count toward resync
        idle(1);
        for (int i = 0; i < 4; i++) cyc(BC, 1'b1, 1'b0, BC, 1'b1, 1'b0);
        wait_up("relink", 5);
        cyc(BC, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        cyc(BC, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        cyc(BC, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(BC, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("loss_comma_ignored", {30'd0, lane_active}, 32'd2);
        cyc(BC, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("loss_comma_resync", {30'd0, lane_active}, 32'd3);
        wait_up("relink2", 40);
        check("retrain_before_sat", {24'd0, retrain_cnt}, 32'd1);

        // Drive retrain_cnt into saturation
        for (int n = 0; n < 256; n++) begin
            for (int i = 0; i < 3; i++) cyc(8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
            for (int i = 0; i < 4; i++) cyc(BC, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            for (int i = 0; i < 40 && !link_up; i++) idle(1);
            if (!link_up) begin
                check("sat_loop_up", {31'd0, link_up}, 32'd1);
                break;
            end
            if (n == 253) check("retrain_254", {24'd0, retrain_cnt}, 32'd255);
        end
        check("retrain_sat", {24'd0, retrain_cnt}, 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
